// File: rtl/seq_divider_16.sv
// Sequential restoring divider: 2*W-bit dividend / W-bit divisor, one quotient bit per clock.
// Optional: define DIV_OVERFLOW_CHECK_EN for quotient-overflow detection and W-cycle runs.
module seq_divider_16 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           dbz,
    output logic           ovf
);

`ifdef DIV_OVERFLOW_CHECK_EN
    localparam int N = W;
`else
    localparam int N = 2 * W;
`endif
    localparam int CW = $clog2(2 * W);
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] dvd_q, dvd_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   pr_q, pr_d;
    logic [W-1:0]   qw_q, qw_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           skip_q, skip_d;
    logic           zp_q, zp_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [W:0]     pr_sh;
    logic [W:0]     diff;
    logic           ge;
    logic [W-1:0]   pr_nx;
    logic [W-1:0]   qw_nx;
    logic           is_zero;
    logic           is_ovf;

    // One restoring step: partial remainder stays below the divisor, so the
    // borrow bit of the W+1-bit difference alone decides the quotient bit.
    always_comb begin
        pr_sh = {pr_q, dvd_q[2*W-1]};
        diff  = pr_sh - {1'b0, dvs_q};
        ge    = ~diff[W];
        pr_nx = ge ? diff[W-1:0] : pr_sh[W-1:0];
        qw_nx = {qw_q[W-2:0], ge};
    end

    // Special-case detection on the operands presented with start.
    always_comb begin
        is_zero = (divisor == '0);
`ifdef DIV_OVERFLOW_CHECK_EN
        is_ovf = ~is_zero && (dividend[2*W-1:W] >= divisor);
`else
        is_ovf = 1'b0;
`endif
    end

    // Next-state and datapath update; results only move on FIN entry.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        qw_d    = qw_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        zp_d    = zp_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            RUN: begin
                if (skip_q) begin
                    state_d = FIN;
                    skip_d  = 1'b0;
                    quo_d   = qw_q;
                    rem_d   = pr_q;
                    dbz_d   = zp_q;
                    ovf_d   = ~zp_q;
                end else begin
                    dvd_d = {dvd_q[2*W-2:0], 1'b0};
                    pr_d  = pr_nx;
                    qw_d  = qw_nx;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = FIN;
                        quo_d   = qw_nx;
                        rem_d   = pr_nx;
                    end
                end
            end
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    dvs_d   = divisor;
                    cnt_d   = CNT_INIT;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    zp_d    = is_zero;
                    dvd_d   = dividend;
                    if (is_zero || is_ovf) begin
                        skip_d = 1'b1;
                        pr_d   = dividend[W-1:0];
                        qw_d   = '1;
                    end else begin
                        skip_d = 1'b0;
                        qw_d   = '0;
`ifdef DIV_OVERFLOW_CHECK_EN
                        pr_d  = dividend[2*W-1:W];
                        dvd_d = {dividend[W-1:0], {W{1'b0}}};
`else
                        pr_d  = '0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any running operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            pr_q   <= '0;
            qw_q   <= '0;
            cnt_q  <= '0;
            skip_q <= 1'b0;
            zp_q   <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            pr_q   <= pr_d;
            qw_q   <= qw_d;
            cnt_q  <= cnt_d;
            skip_q <= skip_d;
            zp_q   <= zp_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN) && !skip_q;
    assign done      = (state_q == FIN);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed table plus corner sequences and random A*B+R checks for seq_divider_16.
// Expectations switch with DIV_OVERFLOW_CHECK_EN.
module tb_seq_divider_16;

`ifdef DIV_OVERFLOW_CHECK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy, done, dbz, ovf;
    logic [7:0]  quotient, remainder;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    seq_divider_16 #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .dbz(dbz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        bit          z;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Latency counted as in the datasheet: start cycle to done cycle.
    task automatic wait_done(output int lat, output bit saw_busy);
        lat = -1;
        saw_busy = busy;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (busy) saw_busy = 1'b1;
            if (done) begin
                lat = k + 1;
                return;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  sb;
        bit  sp;
        logic [7:0] eq, er;
        int  elat;
        int  n0;
        logic [7:0] ra, rb, rr;
        logic [15:0] rd;

        tv[0] = '{16'h3039, 8'h64, 8'h7B, 8'h2D, 1'b0};
        tv[1] = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1};
        tv[2] = '{16'hFFFF, 8'h01, 8'hFF, 8'h00, 1'b0};
        tv[3] = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0};
        tv[4] = '{16'h00FF, 8'hFF, 8'h01, 8'h00, 1'b0};
        tv[5] = '{16'h7FFF, 8'hFF, 8'h80, 8'h7F, 1'b0};
        tv[6] = '{16'h0100, 8'h02, 8'h80, 8'h00, 1'b0};
        tv[7] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0};
        tv[8] = '{16'h1000, 8'h03, 8'h55, 8'h01, 1'b0};
        tv[9] = '{16'h0005, 8'h07, 8'h00, 8'h05, 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {busy, done, quotient, remainder, dbz, ovf}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            sp = EN && !tv[i].z && (tv[i].a[15:8] >= tv[i].b);
            eq = sp ? 8'hFF : tv[i].q;
            er = sp ? tv[i].a[7:0] : tv[i].r;
            elat = (sp || tv[i].z) ? 2 : (EN ? 9 : 17);
            launch(tv[i].a, tv[i].b);
            wait_done(lat, sb);
            chk($sformatf("vec%0d_latency", i), lat, elat);
            chk($sformatf("vec%0d_q", i), quotient, eq);
            chk($sformatf("vec%0d_r", i), remainder, er);
            chk($sformatf("vec%0d_flags", i), {dbz, ovf}, {tv[i].z, sp});
            chk($sformatf("vec%0d_busy", i), sb, !(sp || tv[i].z));
        end

        // Start during RUN is ignored; start in the FIN cycle is accepted.
        repeat (3) @(negedge clk);
        n0 = done_cnt;
        launch(16'h3039, 8'h64);
        repeat (2) @(negedge clk);
        dividend = 16'h1234;
        divisor  = 8'h00;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, sb);
        chk("ignore_start_latency", lat, EN ? 6 : 14);
        chk("ignore_start_result", {quotient, remainder, dbz, ovf}, {8'h7B, 8'h2D, 2'b00});
        launch(16'hFFFF, 8'h01);
        wait_done(lat, sb);
        chk("fin_start_latency", lat, EN ? 2 : 17);
        chk("fin_start_result", {quotient, remainder, dbz, ovf},
            EN ? {8'hFF, 8'hFF, 2'b01} : {8'hFF, 8'h00, 2'b00});
        repeat (25) @(negedge clk);
        chk("done_pulse_count", done_cnt - n0, 2);

        // Asynchronous reset in the middle of a run.
        launch(16'h3039, 8'h64);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_run", {busy, done, quotient, remainder, dbz, ovf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(16'h0100, 8'h02);
        wait_done(lat, sb);
        chk("after_reset_latency", lat, EN ? 9 : 17);
        chk("after_reset_result", {quotient, remainder, dbz, ovf}, {8'h80, 8'h00, 2'b00});

        // Random factor recovery.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            rr = 8'($urandom_range(0, int'(rb) - 1));
            rd = 16'(ra * rb) + 16'(rr);
            @(negedge clk);
            launch(rd, rb);
            wait_done(lat, sb);
            chk($sformatf("rand%0d_latency", i), lat, EN ? 9 : 17);
            @(posedge clk);
            #1;
            chk($sformatf("rand%0d_result", i),
                {quotient, remainder, dbz, ovf, done},
                {ra, rr, 3'b000});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
